rbz_spi_cmd_tx: RTL and testbench

- SPI master (transmitter) that drives the raybox-zero vector and register SPI slave ports (csb/sclk/mosi).
- Accepts one frame at a time over a valid/ready handshake: a right-aligned data word plus a bit length. Serialises it MSB first in SPI mode 0, which the rbzero slaves sample on rising SCLK.
- Used on the host/LA side and in test harnesses. One instance per slave: vec or reg.

---
 rtl/rbz_spi_cmd_tx.sv | 194 +++++++++++++++++++
 tb/tb_rbz_spi_cmd_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbz_spi_cmd_tx.sv
// SPI mode-0 master for the raybox-zero vec/reg slaves: one right-aligned frame
// per valid/ready handshake, shifted out MSB first with fully registered pins.
module rbz_spi_cmd_tx #(
    parameter int unsigned MAX_BITS    = 80,
    parameter int unsigned HALF_PERIOD = 2,
    parameter int unsigned CS_GAP      = 2,
    parameter int unsigned LEN_W       = $clog2(MAX_BITS + 1)
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [MAX_BITS-1:0] i_data,
    input  logic [LEN_W-1:0]    i_len,
    input  logic                i_abort,
    output logic                o_csb,
    output logic                o_sclk,
    output logic                o_mosi,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    localparam int unsigned CNT_MAX = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    bitcnt_q, bitcnt_d;
    logic [MAX_BITS-1:0] shreg_q, shreg_d;
    logic                csb_q, csb_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                len_ok_c;
    logic [LEN_W-1:0]    shamt_c;
    logic                hp_last_c;
    logic                gap_last_c;
    logic                active_c;

    assign len_ok_c   = (i_len != '0) && (i_len <= LEN_W'(MAX_BITS));
    assign shamt_c    = LEN_W'(MAX_BITS) - i_len;
    assign hp_last_c  = (cnt_q == CNT_W'(HALF_PERIOD - 1));
    assign gap_last_c = (cnt_q == CNT_W'(CS_GAP - 1));
    assign active_c   = (state_q == S_SETUP) || (state_q == S_HIGH) ||
                        (state_q == S_LOW)   || (state_q == S_HOLD);

    // Next state, datapath and the pin values to be registered alongside it
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        mosi_d   = mosi_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_valid && ready_q) begin
                    if (len_ok_c) begin
                        state_d  = S_SETUP;
                        cnt_d    = '0;
                        shreg_d  = i_data << shamt_c;
                        bitcnt_d = i_len;
                        mosi_d   = shreg_d[MAX_BITS-1];
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (hp_last_c) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (hp_last_c) begin
                    cnt_d    = '0;
                    bitcnt_d = bitcnt_q - LEN_W'(1);
                    if (bitcnt_q == LEN_W'(1)) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_LOW;
                        shreg_d = shreg_q << 1;
                        mosi_d  = shreg_d[MAX_BITS-1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOW: begin
                if (hp_last_c) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (hp_last_c) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_last_c) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides every in-frame transition, including the final HIGH exit
        if (i_abort && active_c) begin
            state_d  = S_GAP;
            cnt_d    = '0;
            bitcnt_d = '0;
            done_d   = 1'b1;
            err_d    = 1'b1;
        end

        if ((state_d == S_IDLE) || (state_d == S_GAP)) begin
            mosi_d = 1'b0;
        end
        csb_d   = (state_d == S_IDLE) || (state_d == S_GAP);
        sclk_d  = (state_d == S_HIGH);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            csb_q    <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            csb_q    <= csb_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_csb   = csb_q;
    assign o_sclk  = sclk_q;
    assign o_mosi  = mosi_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_rbz_spi_cmd_tx.sv
// Directed bench for rbz_spi_cmd_tx: a negedge slave model collects bits on
// SCLK rises and measures CSB timing; each scenario compares against hand values.
module tb_rbz_spi_cmd_tx;

    localparam int unsigned MAX_BITS = 80;
    localparam int unsigned LEN_W    = 7;

    logic                clk    = 1'b0;
    logic                clk_en = 1'b1;
    logic                rst_n;
    logic                i_valid;
    logic                o_ready;
    logic [MAX_BITS-1:0] i_data;
    logic [LEN_W-1:0]    i_len;
    logic                i_abort;
    logic                o_csb, o_sclk, o_mosi, o_busy, o_done, o_err;

    int checks = 0;
    int errors = 0;

    rbz_spi_cmd_tx #(
        .MAX_BITS   (80),
        .HALF_PERIOD(2),
        .CS_GAP     (2)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_len    (i_len),
        .i_abort  (i_abort),
        .o_csb    (o_csb),
        .o_sclk   (o_sclk),
        .o_mosi   (o_mosi),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Behavioural rbzero slave plus pin-timing monitor
    logic [MAX_BITS-1:0] rx = '0;
    int   rises = 0, csb_low = 0, hi_run = 0, last_hi_run = 0, viol = 0;
    logic prev_sclk = 1'b0, prev_mosi = 1'b0;

    always @(negedge clk) begin
        prev_sclk <= o_sclk;
        prev_mosi <= o_mosi;
        if (!o_csb) csb_low <= csb_low + 1;
        if (o_sclk && !prev_sclk) begin
            rises <= rises + 1;
            rx    <= {rx[MAX_BITS-2:0], o_mosi};
        end
        if (o_sclk && prev_sclk && (o_mosi != prev_mosi)) viol <= viol + 1;
        if (o_csb) begin
            hi_run <= hi_run + 1;
        end else begin
            if (hi_run != 0) last_hi_run <= hi_run;
            hi_run <= 0;
        end
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) check("ready_timeout", 96'(o_ready), 96'd1);
    endtask

    task automatic wait_done(output int n, output logic e);
        n = 0;
        while (!o_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!o_done) check("done_timeout", 96'(o_done), 96'd1);
        e = o_err;
    endtask

    // Issue one frame, scramble the inputs after accept, and wait for o_done
    task automatic send(input logic [MAX_BITS-1:0] d, input logic [LEN_W-1:0] l,
                        output int n, output logic e);
        wait_ready();
        i_valid = 1'b1;
        i_data  = d;
        i_len   = l;
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = ~d;
        i_len   = '0;
        wait_done(n, e);
    endtask

    int   n, r0, c0;
    logic e;
    logic [95:0] rnd;
    logic [MAX_BITS-1:0] word;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_len   = '0;
        i_abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csb",   96'(o_csb),   96'd1);
        check("rst_sclk",  96'(o_sclk),  96'd0);
        check("rst_ready", 96'(o_ready), 96'd1);
        check("rst_busy",  96'(o_busy),  96'd0);
        check("rst_done",  96'(o_done),  96'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0xA5, 8 bits
        r0 = rises; c0 = csb_low;
        send(80'hA5, 7'd8, n, e);
        check("a5_latency", 96'(n), 96'd34);
        check("a5_rises",   96'(rises - r0), 96'd8);
        check("a5_csb_low", 96'(csb_low - c0), 96'd34);
        check("a5_bits",    96'(rx[7:0]), 96'hA5);
        check("a5_err",     96'(e), 96'd0);
        check("a5_gap_csb", 96'(o_csb), 96'd1);
        @(negedge clk);
        check("a5_done_pulse", 96'(o_done), 96'd0);

        // Full-length random word
        rnd  = {$urandom, $urandom, $urandom};
        word = rnd[MAX_BITS-1:0];
        r0 = rises; c0 = csb_low;
        send(word, 7'd80, n, e);
        check("full_rises",   96'(rises - r0), 96'd80);
        check("full_csb_low", 96'(csb_low - c0), 96'd322);
        check("full_word",    96'(rx), 96'(word));
        check("full_err",     96'(e), 96'd0);

        // Back-to-back with i_valid held
        r0 = rises;
        wait_ready();
        i_valid = 1'b1;
        i_data  = 80'h1234;
        i_len   = 7'd16;
        @(negedge clk);
        i_data  = 80'hBEEF;
        wait_done(n, e);
        check("b2b_first", 96'(rx[15:0]), 96'h1234);
        wait_ready();
        @(negedge clk);
        i_valid = 1'b0;
        wait_done(n, e);
        check("b2b_second", 96'(rx[15:0]), 96'hBEEF);
        check("b2b_rises",  96'(rises - r0), 96'd32);
        check("b2b_gap",    96'(last_hi_run), 96'd3);
        check("b2b_err",    96'(e), 96'd0);

        // Length rejection
        r0 = rises; c0 = csb_low;
        send(80'hFF, 7'd0, n, e);
        check("len0_latency", 96'(n), 96'd0);
        check("len0_err",     96'(e), 96'd1);
        @(negedge clk);
        send(80'hFF, 7'd81, n, e);
        check("len81_latency", 96'(n), 96'd0);
        check("len81_err",     96'(e), 96'd1);
        repeat (3) @(negedge clk);
        check("rej_rises",   96'(rises - r0), 96'd0);
        check("rej_csb_low", 96'(csb_low - c0), 96'd0);

        // Abort after the 3rd rising edge
        r0 = rises;
        wait_ready();
        i_valid = 1'b1;
        i_data  = 80'hC3A5;
        i_len   = 7'd16;
        @(negedge clk);
        i_valid = 1'b0;
        n = 0;
        while ((rises - r0) < 3 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_reach", 96'(rises - r0), 96'd3);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort_csb",   96'(o_csb),   96'd1);
        check("abort_sclk",  96'(o_sclk),  96'd0);
        check("abort_done",  96'(o_done),  96'd1);
        check("abort_err",   96'(o_err),   96'd1);
        check("abort_ready", 96'(o_ready), 96'd0);
        @(negedge clk);
        check("abort_ready1", 96'(o_ready), 96'd0);
        @(negedge clk);
        check("abort_ready2", 96'(o_ready), 96'd1);
        check("abort_rises",  96'(rises - r0), 96'd3);
        send(80'h5A3C, 7'd16, n, e);
        check("post_abort_word", 96'(rx[15:0]), 96'h5A3C);
        check("post_abort_err",  96'(e), 96'd0);

        // Reset mid-frame, clock running
        wait_ready();
        i_valid = 1'b1;
        i_data  = 80'hFFFF;
        i_len   = 7'd16;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_csb", 96'(o_csb), 96'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rstrun_csb",   96'(o_csb),   96'd1);
        check("rstrun_sclk",  96'(o_sclk),  96'd0);
        check("rstrun_mosi",  96'(o_mosi),  96'd0);
        check("rstrun_ready", 96'(o_ready), 96'd1);
        check("rstrun_done",  96'(o_done),  96'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-frame, clock stopped
        wait_ready();
        i_valid = 1'b1;
        i_data  = 80'hFFFF;
        i_len   = 7'd16;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (11) @(negedge clk);
        clk_en = 1'b0;
        #20;
        check("pre_rst2_mosi", 96'(o_mosi), 96'd1);
        rst_n = 1'b0;
        #1;
        check("rststop_csb",   96'(o_csb),   96'd1);
        check("rststop_sclk",  96'(o_sclk),  96'd0);
        check("rststop_mosi",  96'(o_mosi),  96'd0);
        check("rststop_ready", 96'(o_ready), 96'd1);
        check("rststop_done",  96'(o_done),  96'd0);
        #5 rst_n = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);

        send(80'h3C, 7'd8, n, e);
        check("post_rst_word", 96'(rx[7:0]), 96'h3C);
        check("post_rst_lat",  96'(n), 96'd34);
        check("mosi_stable_high", 96'(viol), 96'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
